// File: rtl/ec_harness_pkg.sv
// Shared definitions for the serial test harness controller: FSM encoding,
// frame-bit levels and a small sizing helper.
package ec_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_LOAD      = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_SHIFT_OUT = 3'd5
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ec_harness_sync.sv
// Two-flop synchronizer for the serial input pin; resets to the idle-high level.
module ec_harness_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], d};
    end
  end

  assign q = sync_ff[1];

endmodule

// File: rtl/ec_harness_ctrl.sv
// Serial-frame test harness: receives an input word on test_i, runs the core
// once with a timeout, and returns status plus result on test_o.
module ec_harness_ctrl
  import ec_harness_pkg::*;
#(
  parameter int IN_W    = 166,
  parameter int OUT_W   = 327,
  parameter int TMO_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_i,
  output logic             test_o,
  output logic [IN_W-1:0]  core_din,
  output logic             core_start,
  output logic             core_clr,
  input  logic             core_done,
  input  logic [OUT_W-1:0] core_dout
);

  // One bit counter serves both the receive and the transmit shifters.
  localparam int CNT_W = $clog2(max_int(IN_W, OUT_W + 3) + 1);
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic             sync_bit;
  state_t           state;
  logic [IN_W-1:0]  in_sr;
  logic [OUT_W-1:0] out_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             status;

  ec_harness_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (test_i),
    .q     (sync_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      test_o     <= STOP_BIT;
      core_start <= 1'b0;
      core_clr   <= 1'b0;
      core_din   <= '0;
      in_sr      <= '0;
      out_sr     <= '0;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      status     <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_clr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          test_o <= STOP_BIT;
          if (sync_bit == START_BIT) begin
            state   <= ST_SHIFT_IN;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT_IN: begin
          in_sr <= {in_sr[IN_W-2:0], sync_bit};
          if (bit_cnt == CNT_W'(IN_W - 1)) begin
            state   <= ST_LOAD;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_LOAD: begin
          core_din   <= in_sr;
          core_start <= 1'b1;
          state      <= ST_START;
        end
        ST_START: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done is checked first so it wins over a coincident timeout.
          if (core_done) begin
            out_sr  <= core_dout;
            status  <= 1'b1;
            test_o  <= START_BIT;
            bit_cnt <= '0;
            state   <= ST_SHIFT_OUT;
          end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            core_clr <= 1'b1;
            out_sr   <= '0;
            status   <= 1'b0;
            test_o   <= START_BIT;
            bit_cnt  <= '0;
            state    <= ST_SHIFT_OUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_SHIFT_OUT: begin
          // test_o already shows bit bit_cnt; load the next one.
          if (bit_cnt == '0) begin
            test_o <= status;
          end else if (bit_cnt <= CNT_W'(OUT_W)) begin
            test_o <= out_sr[OUT_W-1];
            out_sr <= {out_sr[OUT_W-2:0], 1'b0};
          end else begin
            test_o <= STOP_BIT;
          end
          if (bit_cnt == CNT_W'(OUT_W + 2)) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          test_o <= STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ec_harness_ctrl.sv
// Directed bench for ec_harness_ctrl with a behavioural echo core.
module tb_ec_harness_ctrl;

  localparam int IN_W    = 8;
  localparam int OUT_W   = 12;
  localparam int TMO_CYC = 16;
  localparam int FRM_W   = OUT_W + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             test_i = 1'b1;
  logic             test_o;
  logic [IN_W-1:0]  core_din;
  logic             core_start;
  logic             core_clr;
  logic             core_done = 1'b0;
  logic [OUT_W-1:0] core_dout = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_start = 0, n_clr = 0, n_both = 0;
  int start_cyc = 0, clr_cyc = 0;

  int  done_delay = 5;
  bit  early_done = 1'b0;
  bit  armed = 1'b0;
  int  core_cnt = 0;

  ec_harness_ctrl #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .test_i     (test_i),
    .test_o     (test_o),
    .core_din   (core_din),
    .core_start (core_start),
    .core_clr   (core_clr),
    .core_done  (core_done),
    .core_dout  (core_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor.
  always @(negedge clk) begin
    if (core_start) begin n_start++; start_cyc = cyc; end
    if (core_clr)   begin n_clr++;   clr_cyc   = cyc; end
    if (core_start && core_clr) n_both++;
  end

  // Core model: done on the done_delay-th WAIT cycle (0 = never), echo {din,4'h3}.
  always @(negedge clk) begin
    if (!rst_n) begin
      armed = 1'b0; core_cnt = 0; core_done = 1'b0;
    end else if (core_start) begin
      armed = 1'b1; core_cnt = 0; core_done = early_done;
    end else if (armed) begin
      core_cnt++;
      core_done = (done_delay != 0) && (core_cnt == done_delay);
      if (core_done) armed = 1'b0;
    end else begin
      core_done = 1'b0;
    end
    core_dout = {core_din, 4'h3};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [IN_W-1:0] d);
    @(negedge clk) test_i = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      @(negedge clk) test_i = d[i];
    end
    @(negedge clk) test_i = 1'b1;
  endtask

  task automatic capture(output logic [FRM_W-1:0] frm, output logic seen);
    seen = 1'b0;
    frm  = '0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (test_o == 1'b0) seen = 1'b1;
    end
    if (seen) begin
      frm[FRM_W-1] = test_o;
      for (int i = FRM_W - 2; i >= 0; i--) begin
        @(negedge clk);
        frm[i] = test_o;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [IN_W-1:0] d,
                           input logic [FRM_W-1:0] exp);
    logic [FRM_W-1:0] frm;
    logic seen;
    send_frame(d);
    capture(frm, seen);
    check({tag, "_seen"}, seen, 1'b1);
    check({tag, "_frame"}, frm, exp);
  endtask

  initial begin
    logic [FRM_W-1:0] frm;
    logic seen;
    int s0, c0;

    repeat (3) @(negedge clk);
    check("rst_test_o", test_o, 1'b1);
    check("rst_start", core_start, 1'b0);
    check("rst_clr", core_clr, 1'b0);
    check("rst_din", core_din, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal echo after 5 WAIT cycles.
    s0 = n_start; c0 = n_clr;
    run_frame("echo", 8'hA5, {1'b0, 1'b1, 12'hA53, 1'b1});
    check("echo_din", core_din, 8'hA5);
    check("echo_starts", n_start - s0, 1);
    check("echo_clrs", n_clr - c0, 0);
    @(negedge clk);
    check("echo_idle_high", test_o, 1'b1);

    // Core never finishes: timeout.
    done_delay = 0;
    s0 = n_start; c0 = n_clr;
    run_frame("tmo", 8'h11, {1'b0, 1'b0, 12'h000, 1'b1});
    check("tmo_clrs", n_clr - c0, 1);
    check("tmo_clr_lat", clr_cyc - start_cyc, 17);

    // Done on the 16th WAIT cycle wins over timeout.
    done_delay = 16;
    c0 = n_clr;
    run_frame("edge16", 8'h22, {1'b0, 1'b1, 12'h223, 1'b1});
    check("edge16_clrs", n_clr - c0, 0);

    // Done during START only is ignored; frame times out.
    done_delay = 0; early_done = 1'b1;
    c0 = n_clr;
    run_frame("early", 8'h44, {1'b0, 1'b0, 12'h000, 1'b1});
    check("early_clrs", n_clr - c0, 1);
    early_done = 1'b0; done_delay = 5;

    // Reset in the middle of SHIFT_OUT.
    send_frame(8'h77);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (test_o == 1'b0) seen = 1'b1;
    end
    check("midrst_seen", seen, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_test_o", test_o, 1'b1);
    check("midrst_din", core_din, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("post_rst", 8'h3C, {1'b0, 1'b1, 12'h3C3, 1'b1});

    // Toggle test_i during WAIT/SHIFT_OUT.
    s0 = n_start;
    send_frame(8'h5A);
    fork
      begin
        for (int i = 0; i < 60 && !core_start; i++) @(negedge clk);
        for (int i = 0; i < 15; i++) @(negedge clk) test_i = ~test_i;
        @(negedge clk) test_i = 1'b1;
      end
      capture(frm, seen);
    join
    check("toggle_seen", seen, 1'b1);
    check("toggle_frame", frm, {1'b0, 1'b1, 12'h5A3, 1'b1});
    check("toggle_starts", n_start - s0, 1);
    repeat (5) @(negedge clk);

    // Back-to-back frames: second starts right after the first stop bit.
    s0 = n_start;
    run_frame("b2b_a", 8'hC3, {1'b0, 1'b1, 12'hC33, 1'b1});
    run_frame("b2b_b", 8'h0F, {1'b0, 1'b1, 12'h0F3, 1'b1});
    check("b2b_starts", n_start - s0, 2);

    check("start_clr_overlap", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ec_harness_ctrl.md
EC_HARNESS_CTRL -- requirements
Module: ec_harness_ctrl

Interface
REQ-001 Parameter IN_W, default 166, core input word width in bits (>=2).
REQ-002 Parameter OUT_W, default 327, core output word width in bits (>=2).
REQ-003 Parameter TMO_CYC, default 1000000, max WAIT cycles before timeout (>=2); counter width = clog2(TMO_CYC+1).
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  one clock; reset is asynchronous and active-low.
REQ-006 test_i  in  1  serial frame input pin, idle high.
REQ-007 test_o  out  1  serial frame output pin, idle high.
REQ-008 core_din  out  IN_W  word driven to the core; stable outside LOAD.
REQ-009 core_start  out  1  one-cycle start pulse to the core.
REQ-010 core_clr  out  1  one-cycle clear pulse to the core on timeout.
REQ-011 core_done  in  1  core completion flag, sampled only in WAIT.
REQ-012 core_dout  in  OUT_W  core result, captured on done.

Function
REQ-013 test_i shall pass through a 2-flop synchronizer (flops reset to 1); "sync bit" means its output.
REQ-014 FSM states: IDLE, SHIFT_IN, LOAD, START, WAIT, SHIFT_OUT.
REQ-015 IDLE: test_o=1; sync bit 0 (start bit) -> SHIFT_IN, bit counter cleared.
REQ-016 SHIFT_IN: one sync bit per cycle shifted into in_sr, MSB first; after exactly IN_W bits -> LOAD.
REQ-017 LOAD: core_din <= in_sr in one cycle; -> START.
REQ-018 START: core_start=1 for exactly this cycle; timeout counter cleared; -> WAIT.
REQ-019 WAIT: core_done=1 -> out_sr <= core_dout, status <= 1, -> SHIFT_OUT.
REQ-020 WAIT: counter increments per cycle without done; at TMO_CYC WAIT cycles -> core_clr=1 one cycle, out_sr <= 0, status <= 0, -> SHIFT_OUT.
REQ-021 Done and timeout in the same cycle: done wins, status=1, no core_clr.
REQ-022 SHIFT_OUT: test_o emits start bit 0, status bit, OUT_W data bits MSB first, stop bit 1 (OUT_W+3 cycles), then -> IDLE.
REQ-023 test_i ignored outside IDLE/SHIFT_IN; next frame accepted only from IDLE, earliest the cycle after the stop bit.
REQ-024 core_done ignored outside WAIT; done asserted during START has no effect.
REQ-025 core_start and core_clr never both 1 in one cycle.

Reset
REQ-026 rst_n low at any time, including mid-frame: state=IDLE, test_o=1, core_start=0, core_clr=0, core_din=0, in_sr=0, out_sr=0, counters=0, status=0.
REQ-027 After rst_n deasserts, first frame accepted once synchronizer output is 0 (2-cycle latency).

Structure
REQ-028 State encodings and frame-bit constants (START_BIT=0, STOP_BIT=1) shall live in shared package ec_harness_pkg.
REQ-029 Synchronizer shall be sub-module ec_harness_sync (2 flops, async reset to 1); rest is a single FSM.
REQ-030 Implementation size 120-400 lines RTL; no vendor primitives.

Verification (IN_W=8, OUT_W=12, TMO_CYC=16, behavioural core model)
REQ-031 Frame 0,0xA5 with core echoing {din,4'h3} after 5 cycles -> core_din=0xA5, one core_start pulse, test_o = 0,1,0xA53 MSB-first,1.
REQ-032 Core never asserts done -> core_clr pulse exactly 16 WAIT cycles after start; test_o = 0,0,0x000,1.
REQ-033 Done asserted on the 16th WAIT cycle -> status 1, no core_clr.
REQ-034 rst_n pulsed low mid-SHIFT_OUT -> test_o=1 immediately, core_din=0; subsequent frame 0x3C completes normally.
REQ-035 Toggling test_i during WAIT/SHIFT_OUT -> no extra core_start, output frame unchanged; back-to-back frames both processed.
